// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-GPR in-flight write tracker feeding the ID hazard check.
// Define SB_WB_BYPASS_EN to mask busy for a register whose last owed write retires this cycle.
module reg_scoreboard #(
  parameter int DEPTH = 3,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic [4:0]    issue_dest,
  input  logic          issue_load_op,
  output logic          issue_ready,
  input  logic          wb_valid,
  input  logic [4:0]    wb_dest,
  input  logic          flush,
  input  logic [4:0]    id_raddr1,
  input  logic [4:0]    id_raddr2,
  output logic          r1_busy,
  output logic          r2_busy,
  output logic          r1_load_busy,
  output logic          r2_load_busy,
  output logic [CW-1:0] inflight,
  output logic          underflow_err
);
  localparam logic [CW-1:0] DMAX = CW'(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);
  logic [31:0][CW-1:0] cnt, cnt_n;
  logic [31:0] ld, ld_n;
  logic [CW-1:0] total, total_n;
  logic ret, uf, iss, byp1, byp2;
  // only a retire that pays off a tracked write frees a slot; an underflow retire must not
  assign ret = wb_valid && wb_dest != 5'd0 && cnt[wb_dest] != '0;
  assign uf = wb_valid && wb_dest != 5'd0 && cnt[wb_dest] == '0;
  assign issue_ready = !flush && (total < DMAX || ret) &&
                       (cnt[issue_dest] < DMAX || (ret && wb_dest == issue_dest));
  assign iss = issue_valid && issue_ready && issue_dest != 5'd0;
  always_comb begin
    cnt_n = cnt;
    ld_n = ld;
    total_n = total + (iss ? ONE : '0) - (ret ? ONE : '0);
    for (int i = 1; i < 32; i++) begin
      if (ret && wb_dest == 5'(i)) begin
        cnt_n[i] = cnt[i] - ONE;
        ld_n[i] = (cnt[i] == ONE) ? 1'b0 : ld[i];
      end
      if (iss && issue_dest == 5'(i)) begin
        cnt_n[i] = cnt_n[i] + ONE;
        ld_n[i] = issue_load_op;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      ld <= '0;
      total <= '0;
      underflow_err <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
      ld <= '0;
      total <= '0;
    end else begin
      cnt <= cnt_n;
      ld <= ld_n;
      total <= total_n;
      if (uf) underflow_err <= 1'b1;
    end
  end
`ifdef SB_WB_BYPASS_EN
  assign byp1 = wb_valid && wb_dest == id_raddr1 && cnt[id_raddr1] == ONE;
  assign byp2 = wb_valid && wb_dest == id_raddr2 && cnt[id_raddr2] == ONE;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  assign r1_busy = cnt[id_raddr1] != '0 && !byp1;
  assign r2_busy = cnt[id_raddr2] != '0 && !byp2;
  assign r1_load_busy = ld[id_raddr1] && r1_busy;
  assign r2_load_busy = ld[id_raddr2] && r2_busy;
  assign inflight = total;
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-write scoreboard for the five-stage LoongArch pipeline: tracks every in-flight GPR destination from the moment an instruction leaves ID until its WB write retires. It is the producer side of the ID-stage hazard check. It answers "is this source register still owed a write, and is that write a load?" from registered state instead of per-stage dest comparison. It sits beside the ID stage, fed by the ID→EXE issue handshake and the WB write port.

## Interface
Parameters:
- DEPTH, 3, maximum instructions in flight between ID issue and WB retire; also the per-register count ceiling.
- CW, 2, per-register and total counter width; requires 2^CW > DEPTH.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high; clears all state
- issue_valid  in  1  instruction moves ID→EXE this cycle (ds_to_es_valid && es_allowin)
- issue_dest  in  5  destination GPR of issuing instruction; 0 = no write
- issue_load_op  in  1  issuing instruction is a load
- issue_ready  out  1  scoreboard can accept an issue this cycle
- wb_valid  in  1  WB writes the register file this cycle
- wb_dest  in  5  WB destination GPR
- flush  in  1  exception/ertn flush; discards all in-flight entries
- id_raddr1, id_raddr2  in  5 each  ID source register addresses
- r1_busy, r2_busy  out  1 each  source has an outstanding write
- r1_load_busy, r2_load_busy  out  1 each  youngest outstanding write to source is a load
- inflight  out  CW  total outstanding tracked writes
- underflow_err  out  1  sticky: retire seen for a register with count 0

## Operation
- State: cnt[r] (CW bits, r=1..31), ld[r] (1 bit), total (CW bits), underflow_err. r0 is never tracked; its outputs are always 0.
- Issue accepted = issue_valid && issue_ready && issue_dest≠0. On acceptance: cnt[issue_dest]+1, total+1, ld[issue_dest]←issue_load_op. The youngest writer wins.
- Retire = wb_valid && wb_dest≠0. If cnt[wb_dest]>0: cnt−1, total−1. If the result is 0, ld←0. If cnt==0: no count change, underflow_err←1.
- Issue and retire on the same register in the same cycle: cnt unchanged, ld←issue_load_op, total unchanged.
- issue_ready = !flush && (total<DEPTH || retire) && (cnt[issue_dest]<DEPTH || retire to same reg). issue_ready is combinational and does not depend on issue_valid.
- Issue with issue_valid=1 while issue_ready=0 is dropped; no state change.
- flush: all cnt, ld, total ← 0 on the next edge. Issue and retire in the same cycle are ignored. underflow_err is kept.
- rN_busy = cnt[id_raddrN]≠0. rN_load_busy = ld[id_raddrN] && rN_busy.

## Timing
- Reset: all cnt/ld/total 0, underflow_err 0, issue_ready 1, all busy outputs 0, inflight 0.
- All state updates on posedge clk. Query outputs are combinational from registered state plus id_raddr (and wb inputs if bypass is enabled).
- Issue at edge N is visible as busy in cycle N+1. Retire at edge N clears busy in cycle N+1, unless bypass is enabled.
- Counter saturates at DEPTH; it never wraps. Underflow never wraps below 0.
- Asserting reset mid-operation clears state immediately, regardless of clk. After deassertion, the first edge behaves as from empty.

## Configuration
- SB_WB_BYPASS_EN defined: in the same cycle, rN_busy and rN_load_busy are masked when cnt[id_raddrN]==1 && wb_valid && wb_dest==id_raddrN. This models register-file write-through.
- Undefined: busy follows registered cnt only. A register retiring this cycle still reads busy until the next cycle.

## Test plan
- Reset, then issue dest=5 (non-load) → cycle later r1_busy=1 for raddr1=5, inflight=1. Retire 5 → next cycle busy=0, inflight=0.
- Issue dest=7 load, then dest=7 ALU → cnt=2, r1_load_busy=0. Retire once → busy=1. Retire again → busy=0.
- Issue 3 different dests with no retire → inflight=3, issue_ready=0. Fourth issue is dropped. A retire in the same cycle as the fourth issue → accepted, inflight stays 3.
- Same-cycle issue and retire on reg 9 with cnt=1 → cnt stays 1, ld updated. Retire reg 12 with cnt=0 → underflow_err=1 (sticky).
- Flush with 2 in flight plus a concurrent issue → next cycle inflight=0, all busy=0.
- With SB_WB_BYPASS_EN: cnt[4]=1, wb_dest=4, raddr1=4 → r1_busy=0 in that cycle. Without the macro → r1_busy=1.
